// File: rtl/wb_queue_rv.sv
// Writeback queue: round-robin collection of producer results into an in-order FIFO
// that drains into the single register-file write port, with youngest-match forwarding.
module wb_queue_rv #(
    parameter int NSRC     = 2,
    parameter int NRWORD   = 2,
    parameter int BITWIDTH = 32,
    parameter int ADDRW    = 5,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src_valid,
    output logic [NSRC-1:0]           src_ready,
    input  logic [ADDRW-1:0]          src_rd   [NSRC],
    input  logic [BITWIDTH-1:0]       src_data [NSRC],
    input  logic                      rf_stall,
    output logic                      rf_wr,
    output logic                      rf_wd,
    output logic [BITWIDTH-1:0]       rf_write_reg,
    output logic [BITWIDTH-1:0]       rf_write_data,
    input  logic [ADDRW-1:0]          fwd_reg  [NRWORD],
    output logic [NRWORD-1:0]         fwd_hit,
    output logic [BITWIDTH-1:0]       fwd_data [NRWORD],
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int RRW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [ADDRW-1:0]    q_rd   [DEPTH];
    logic [BITWIDTH-1:0] q_data [DEPTH];

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [RRW-1:0]   rr_ptr;
    logic [RRW-1:0]   rr_next;
    logic [RRW-1:0]   grant_idx;
    logic             grant_any;
    logic             full;
    logic             empty;
    logic             accept;
    logic             enq;
    logic             pop;
    logic [ADDRW-1:0] acc_rd;
    logic [PW-1:0]    head;

    // Occupancy falls out of the wrap-bit pointers, so reset clears it with them.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = rd_ptr[PW-1:0];

    always_comb begin
        logic [RRW:0] idx;
        idx       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = {1'b0, rr_ptr} + (RRW+1)'(k);
            if (idx >= (RRW+1)'(NSRC)) begin
                idx = idx - (RRW+1)'(NSRC);
            end
            if (!grant_any && src_valid[idx[RRW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[RRW-1:0];
            end
        end
    end

    assign accept    = grant_any & ~full & ~rst;
    assign src_ready = accept ? (NSRC'(1) << grant_idx) : '0;
    assign acc_rd    = src_rd[grant_idx];
    assign enq       = accept & (acc_rd != '0);
    assign rr_next   = (grant_idx == RRW'(NSRC - 1)) ? '0 : grant_idx + 1'b1;

    assign pop           = ~empty & ~rf_stall;
    assign rf_wr         = pop;
    assign rf_wd         = pop;
    assign rf_write_reg  = empty ? '0 : BITWIDTH'(q_rd[head]);
    assign rf_write_data = empty ? '0 : q_data[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            if (enq)    wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept) rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[wr_ptr[PW-1:0]]   <= acc_rd;
            q_data[wr_ptr[PW-1:0]] <= src_data[grant_idx];
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [PW-1:0] slot;
        slot     = '0;
        fwd_hit  = '0;
        for (int unsigned i = 0; i < NRWORD; i++) begin
            fwd_data[i] = '0;
        end
        for (int unsigned i = 0; i < NRWORD; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot = head + PW'(k);
                if (((PW+1)'(k) < count) && (fwd_reg[i] != '0) && (q_rd[slot] == fwd_reg[i])) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = q_data[slot];
                end
            end
        end
    end

endmodule
